// File: rtl/ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_master_arbiter
//
// Two-master AHB-Lite arbiter that sits in front of the slave mux/decoder.
// Master 0 is the Cortex-M0 and master 1 is the DMA/debug master. The losing
// master is stalled through its own HREADY. Read data that arrives while its
// owner is stalled is parked in a holding register until that master sees
// HREADY high again. The slaves are zero-wait, so one address phase completes
// per cycle.
//
// Parameters:
//   MAX_HOLD     - max consecutive address phases given to one master while
//                  the other master is requesting
//   CPU_PRIORITY - 1: master 0 wins ties, 0: round-robin on ties
//
// Ports:
//   HCLK, HRESET              clock, synchronous active-high reset
//   H*_m0 / H*_m1 (in)        master-side address, control and write data
//   HREADY_m0/m1, HRDATA_m0/m1 (out) per-master ready and read data
//   HADDR..HWDATA (out)       muxed bus towards the slave mux
//   HRDATA (in)               read data from the slave mux
//   HMASTER (out)             owner of the current address phase
// ---------------------------------------------------------------------------
module ahb_master_arbiter #(
  parameter int MAX_HOLD     = 8,
  parameter int CPU_PRIORITY = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR_m0,
  input  logic [31:0] HADDR_m1,
  input  logic [1:0]  HTRANS_m0,
  input  logic [1:0]  HTRANS_m1,
  input  logic        HWRITE_m0,
  input  logic        HWRITE_m1,
  input  logic [2:0]  HSIZE_m0,
  input  logic [2:0]  HSIZE_m1,
  input  logic [2:0]  HBURST_m0,
  input  logic [2:0]  HBURST_m1,
  input  logic [3:0]  HPROT_m0,
  input  logic [3:0]  HPROT_m1,
  input  logic        HMASTLOCK_m0,
  input  logic        HMASTLOCK_m1,
  input  logic [31:0] HWDATA_m0,
  input  logic [31:0] HWDATA_m1,
  output logic        HREADY_m0,
  output logic        HREADY_m1,
  output logic [31:0] HRDATA_m0,
  output logic [31:0] HRDATA_m1,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  output logic        HMASTER
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  logic          req_m0;
  logic          req_m1;
  logic          last_gnt;
  logic          gnt;
  logic          issued;
  logic          lock_keep;
  logic [HW-1:0] hold_cnt;
  logic          dph_valid;
  logic          dph_owner;
  logic          dph_write;
  logic          owner_ready;
  logic          rd_capture;
  logic          rhold_valid_m0;
  logic          rhold_valid_m1;
  logic [31:0]   rhold_data_m0;
  logic [31:0]   rhold_data_m1;

  assign req_m0 = HTRANS_m0[1];
  assign req_m1 = HTRANS_m1[1];

  // A locked owner keeps the bus only while it is still requesting; once the
  // lock drops the normal rules, including the hold limit, apply that cycle.
  assign lock_keep = last_gnt ? (HMASTLOCK_m1 && req_m1)
                              : (HMASTLOCK_m0 && req_m0);

  // Grant selection, evaluated in the same cycle as the requests.
  always_comb begin
    gnt = last_gnt;
    if (HRESET) begin
      gnt = 1'b0;
    end else if (lock_keep) begin
      gnt = last_gnt;
    end else if (req_m0 && !req_m1) begin
      gnt = 1'b0;
    end else if (req_m1 && !req_m0) begin
      gnt = 1'b1;
    end else if (req_m0 && req_m1) begin
      if (hold_cnt >= HOLD_MAX) begin
        gnt = ~last_gnt;
      end else if (CPU_PRIORITY != 0) begin
        gnt = 1'b0;
      end else begin
        gnt = ~last_gnt;
      end
    end
  end

  // The granted master always requests, so any request means an issue.
  assign issued = !HRESET && (req_m0 || req_m1);

  // Address/control follow the grant; write data follows the data-phase owner.
  always_comb begin
    HADDR     = gnt ? HADDR_m1     : HADDR_m0;
    HTRANS    = issued ? (gnt ? HTRANS_m1 : HTRANS_m0) : 2'b00;
    HWRITE    = gnt ? HWRITE_m1    : HWRITE_m0;
    HSIZE     = gnt ? HSIZE_m1     : HSIZE_m0;
    HBURST    = gnt ? HBURST_m1    : HBURST_m0;
    HPROT     = gnt ? HPROT_m1     : HPROT_m0;
    HMASTLOCK = gnt ? HMASTLOCK_m1 : HMASTLOCK_m0;
    HMASTER   = gnt;
    HWDATA    = dph_owner ? HWDATA_m1 : HWDATA_m0;
  end

  assign HREADY_m0 = HRESET || !req_m0 || (gnt == 1'b0);
  assign HREADY_m1 = HRESET || !req_m1 || (gnt == 1'b1);

  // Read data for a stalled owner must be parked, since that master will not
  // sample HRDATA until its HREADY goes high again.
  assign owner_ready = dph_owner ? HREADY_m1 : HREADY_m0;
  assign rd_capture  = dph_valid && !dph_write && !owner_ready;

  always_comb begin
    HRDATA_m0 = HRDATA;
    HRDATA_m1 = HRDATA;
    if (HRESET) begin
      HRDATA_m0 = '0;
      HRDATA_m1 = '0;
    end else begin
      if (rhold_valid_m0) HRDATA_m0 = rhold_data_m0;
      if (rhold_valid_m1) HRDATA_m1 = rhold_data_m1;
    end
  end

  // Grant history, hold counter, data-phase tracking and read holding regs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_gnt       <= 1'b0;
      hold_cnt       <= '0;
      dph_valid      <= 1'b0;
      dph_owner      <= 1'b0;
      dph_write      <= 1'b0;
      rhold_valid_m0 <= 1'b0;
      rhold_valid_m1 <= 1'b0;
      rhold_data_m0  <= '0;
      rhold_data_m1  <= '0;
    end else begin
      last_gnt <= gnt;
      if (!issued) begin
        hold_cnt <= '0;
      end else if (gnt != last_gnt) begin
        hold_cnt <= HW'(1);
      end else if (hold_cnt < HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      dph_valid <= issued;
      dph_owner <= gnt;
      dph_write <= HWRITE;
      if (rd_capture && !dph_owner) begin
        rhold_valid_m0 <= 1'b1;
        rhold_data_m0  <= HRDATA;
      end else if (HREADY_m0) begin
        rhold_valid_m0 <= 1'b0;
      end
      if (rd_capture && dph_owner) begin
        rhold_valid_m1 <= 1'b1;
        rhold_data_m1  <= HRDATA;
      end else if (HREADY_m1) begin
        rhold_valid_m1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_arbiter
//
// Self-checking bench for ahb_master_arbiter. Two instances share the master
// and slave stimulus: dut_p uses CPU priority and dut_r uses round-robin.
// rr_sel chooses which instance the checks observe. Expected grants come from
// fixed per-test patterns. Expected read data is pushed to a per-master queue
// when the slave drives it and popped when that master is expected to be
// ready.
// ---------------------------------------------------------------------------
module tb_ahb_master_arbiter;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] NONSEQ  = 2'b10;

  logic        HCLK;
  logic        HRESET;
  logic [31:0] HADDR_m0, HADDR_m1;
  logic [1:0]  HTRANS_m0, HTRANS_m1;
  logic        HWRITE_m0, HWRITE_m1;
  logic [2:0]  HSIZE_m0, HSIZE_m1;
  logic [2:0]  HBURST_m0, HBURST_m1;
  logic [3:0]  HPROT_m0, HPROT_m1;
  logic        HMASTLOCK_m0, HMASTLOCK_m1;
  logic [31:0] HWDATA_m0, HWDATA_m1;
  logic [31:0] HRDATA;

  logic        hready_m0_p, hready_m1_p, hready_m0_r, hready_m1_r;
  logic [31:0] hrdata_m0_p, hrdata_m1_p, hrdata_m0_r, hrdata_m1_r;
  logic [31:0] haddr_p, haddr_r, hwdata_p, hwdata_r;
  logic [1:0]  htrans_p, htrans_r;
  logic        hwrite_p, hwrite_r, hmastlock_p, hmastlock_r;
  logic [2:0]  hsize_p, hsize_r, hburst_p, hburst_r;
  logic [3:0]  hprot_p, hprot_r;
  logic        hmaster_p, hmaster_r;

  logic        rr_sel;
  logic        obs_master, obs_rdy0, obs_rdy1;
  logic [31:0] obs_addr, obs_wdata, obs_rd0, obs_rd1;
  logic [1:0]  obs_trans;
  logic [11:0] obs_ctrl;

  int          tests_run;
  int          tests_failed;
  int          cycle_no;
  logic [31:0] addr0, addr1;
  logic        dph_valid, dph_owner, dph_write;
  logic [31:0] rd_q0[$];
  logic [31:0] rd_q1[$];
  logic [31:0] slave_override;
  logic        use_override;

  ahb_master_arbiter #(.MAX_HOLD(8), .CPU_PRIORITY(1)) dut_p (
    .HCLK(HCLK), .HRESET(HRESET),
    .HADDR_m0(HADDR_m0), .HADDR_m1(HADDR_m1),
    .HTRANS_m0(HTRANS_m0), .HTRANS_m1(HTRANS_m1),
    .HWRITE_m0(HWRITE_m0), .HWRITE_m1(HWRITE_m1),
    .HSIZE_m0(HSIZE_m0), .HSIZE_m1(HSIZE_m1),
    .HBURST_m0(HBURST_m0), .HBURST_m1(HBURST_m1),
    .HPROT_m0(HPROT_m0), .HPROT_m1(HPROT_m1),
    .HMASTLOCK_m0(HMASTLOCK_m0), .HMASTLOCK_m1(HMASTLOCK_m1),
    .HWDATA_m0(HWDATA_m0), .HWDATA_m1(HWDATA_m1),
    .HREADY_m0(hready_m0_p), .HREADY_m1(hready_m1_p),
    .HRDATA_m0(hrdata_m0_p), .HRDATA_m1(hrdata_m1_p),
    .HADDR(haddr_p), .HTRANS(htrans_p), .HWRITE(hwrite_p), .HSIZE(hsize_p),
    .HBURST(hburst_p), .HPROT(hprot_p), .HMASTLOCK(hmastlock_p),
    .HWDATA(hwdata_p), .HRDATA(HRDATA), .HMASTER(hmaster_p)
  );

  ahb_master_arbiter #(.MAX_HOLD(8), .CPU_PRIORITY(0)) dut_r (
    .HCLK(HCLK), .HRESET(HRESET),
    .HADDR_m0(HADDR_m0), .HADDR_m1(HADDR_m1),
    .HTRANS_m0(HTRANS_m0), .HTRANS_m1(HTRANS_m1),
    .HWRITE_m0(HWRITE_m0), .HWRITE_m1(HWRITE_m1),
    .HSIZE_m0(HSIZE_m0), .HSIZE_m1(HSIZE_m1),
    .HBURST_m0(HBURST_m0), .HBURST_m1(HBURST_m1),
    .HPROT_m0(HPROT_m0), .HPROT_m1(HPROT_m1),
    .HMASTLOCK_m0(HMASTLOCK_m0), .HMASTLOCK_m1(HMASTLOCK_m1),
    .HWDATA_m0(HWDATA_m0), .HWDATA_m1(HWDATA_m1),
    .HREADY_m0(hready_m0_r), .HREADY_m1(hready_m1_r),
    .HRDATA_m0(hrdata_m0_r), .HRDATA_m1(hrdata_m1_r),
    .HADDR(haddr_r), .HTRANS(htrans_r), .HWRITE(hwrite_r), .HSIZE(hsize_r),
    .HBURST(hburst_r), .HPROT(hprot_r), .HMASTLOCK(hmastlock_r),
    .HWDATA(hwdata_r), .HRDATA(HRDATA), .HMASTER(hmaster_r)
  );

  assign obs_master = rr_sel ? hmaster_r   : hmaster_p;
  assign obs_rdy0   = rr_sel ? hready_m0_r : hready_m0_p;
  assign obs_rdy1   = rr_sel ? hready_m1_r : hready_m1_p;
  assign obs_addr   = rr_sel ? haddr_r     : haddr_p;
  assign obs_trans  = rr_sel ? htrans_r    : htrans_p;
  assign obs_wdata  = rr_sel ? hwdata_r    : hwdata_p;
  assign obs_rd0    = rr_sel ? hrdata_m0_r : hrdata_m0_p;
  assign obs_rd1    = rr_sel ? hrdata_m1_r : hrdata_m1_p;
  assign obs_ctrl   = rr_sel ? {hwrite_r, hsize_r, hburst_r, hprot_r, hmastlock_r}
                             : {hwrite_p, hsize_p, hburst_p, hprot_p, hmastlock_p};

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Counts one comparison and reports it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               tag, actual, expected, cycle_no);
    end
  endtask

  // Asserts reset for one edge with the master inputs left as they are, checks
  // the reset outputs, then releases reset and drops all master requests.
  task automatic applyReset();
    @(negedge HCLK);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    checkOutput("rst_htrans", 32'(obs_trans), 32'd0);
    checkOutput("rst_hmaster", 32'(obs_master), 32'd0);
    checkOutput("rst_hready_m0", 32'(obs_rdy0), 32'd1);
    checkOutput("rst_hready_m1", 32'(obs_rdy1), 32'd1);
    checkOutput("rst_hrdata_m0", obs_rd0, 32'd0);
    checkOutput("rst_hrdata_m1", obs_rd1, 32'd0);
    HRESET       = 1'b0;
    HTRANS_m0    = IDLE;
    HTRANS_m1    = IDLE;
    HWRITE_m0    = 1'b0;
    HWRITE_m1    = 1'b0;
    HMASTLOCK_m0 = 1'b0;
    HMASTLOCK_m1 = 1'b0;
    dph_valid    = 1'b0;
    rd_q0.delete();
    rd_q1.delete();
  endtask

  // Drives one bus cycle and checks it against the expected grant. A stalled
  // master keeps its address because addresses only advance on an issue.
  task automatic applyStimulus(input logic [1:0] tr0, input logic [1:0] tr1,
                               input logic wr0, input logic wr1,
                               input logic lk0, input logic lk1,
                               input logic [31:0] wd0, input logic [31:0] wd1,
                               input logic exp_gnt);
    logic        req0, req1, any_req, exp_rdy0, exp_rdy1;
    logic [31:0] slave_data;
    logic [11:0] ctrl0, ctrl1;
    @(negedge HCLK);
    HTRANS_m0 = tr0; HWRITE_m0 = wr0; HMASTLOCK_m0 = lk0; HWDATA_m0 = wd0; HADDR_m0 = addr0;
    HTRANS_m1 = tr1; HWRITE_m1 = wr1; HMASTLOCK_m1 = lk1; HWDATA_m1 = wd1; HADDR_m1 = addr1;
    slave_data = use_override ? slave_override : (32'hC0DE_0000 + 32'(cycle_no));
    use_override = 1'b0;
    HRDATA = slave_data;
    #1;
    req0    = tr0[1];
    req1    = tr1[1];
    any_req = req0 || req1;
    ctrl0   = {wr0, HSIZE_m0, HBURST_m0, HPROT_m0, lk0};
    ctrl1   = {wr1, HSIZE_m1, HBURST_m1, HPROT_m1, lk1};
    if (dph_valid && !dph_write) begin
      if (dph_owner) rd_q1.push_back(slave_data);
      else rd_q0.push_back(slave_data);
    end
    exp_rdy0 = !req0 || (exp_gnt == 1'b0);
    exp_rdy1 = !req1 || (exp_gnt == 1'b1);
    checkOutput("hready_m0", 32'(obs_rdy0), 32'(exp_rdy0));
    checkOutput("hready_m1", 32'(obs_rdy1), 32'(exp_rdy1));
    if (any_req) begin
      checkOutput("hmaster", 32'(obs_master), 32'(exp_gnt));
      checkOutput("haddr", obs_addr, exp_gnt ? addr1 : addr0);
      checkOutput("htrans", 32'(obs_trans), 32'(exp_gnt ? tr1 : tr0));
      checkOutput("hctrl", 32'(obs_ctrl), 32'(exp_gnt ? ctrl1 : ctrl0));
    end else begin
      checkOutput("htrans_idle", 32'(obs_trans), 32'd0);
    end
    if (dph_valid && dph_write) begin
      checkOutput("hwdata", obs_wdata, dph_owner ? wd1 : wd0);
    end
    if (exp_rdy0 && rd_q0.size() > 0) checkOutput("hrdata_m0", obs_rd0, rd_q0.pop_front());
    if (exp_rdy1 && rd_q1.size() > 0) checkOutput("hrdata_m1", obs_rd1, rd_q1.pop_front());
    dph_valid = any_req;
    dph_owner = exp_gnt;
    dph_write = exp_gnt ? wr1 : wr0;
    if (any_req) begin
      if (exp_gnt) addr1 = addr1 + 32'd4;
      else addr0 = addr0 + 32'd4;
    end
    cycle_no++;
  endtask

  task automatic idleCycle();
    applyStimulus(IDLE, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; cycle_no = 0;
    rr_sel = 1'b0; use_override = 1'b0; slave_override = '0;
    dph_valid = 1'b0; dph_owner = 1'b0; dph_write = 1'b0;
    HRESET = 1'b1; HRDATA = '0;
    HADDR_m0 = '0; HADDR_m1 = '0; HTRANS_m0 = IDLE; HTRANS_m1 = IDLE;
    HWRITE_m0 = 1'b0; HWRITE_m1 = 1'b0; HMASTLOCK_m0 = 1'b0; HMASTLOCK_m1 = 1'b0;
    HWDATA_m0 = '0; HWDATA_m1 = '0;
    HSIZE_m0 = 3'b010; HSIZE_m1 = 3'b000;
    HBURST_m0 = 3'b001; HBURST_m1 = 3'b000;
    HPROT_m0 = 4'b0011; HPROT_m1 = 4'b0001;
    addr0 = 32'h2000_0000; addr1 = 32'h3000_0000;

    applyReset();

    // m0 alone: four NONSEQ reads, data comes straight through next cycle.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(NONSEQ, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    end
    idleCycle();

    // Both requesting under CPU priority: eight m0 grants, then one m1 grant.
    for (int k = 0; k < 18; k++) begin
      applyStimulus(NONSEQ, NONSEQ, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, (k % 9) == 8);
    end
    idleCycle();

    // m1 holds a locked sequence of 12 transfers; m0 wins when the lock drops.
    applyStimulus(IDLE, NONSEQ, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    for (int k = 1; k < 12; k++) begin
      applyStimulus(NONSEQ, NONSEQ, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    end
    applyStimulus(NONSEQ, NONSEQ, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    idleCycle();

    // m0 write followed at once by an m1 grant: write data still from m0.
    addr0 = 32'h4000_2000;
    applyStimulus(NONSEQ, IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    applyStimulus(IDLE, NONSEQ, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_00A5, 32'h5A5A_5A5A, 1'b1);
    idleCycle();

    // Round-robin instance: grants alternate and parked read data is returned.
    applyReset();
    rr_sel = 1'b1;
    addr0 = 32'h2000_0100; addr1 = 32'h3000_0100;
    applyStimulus(NONSEQ, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    slave_override = 32'hDEAD_BEEF;
    use_override = 1'b1;
    for (int k = 1; k < 9; k++) begin
      applyStimulus(NONSEQ, NONSEQ, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, (k % 2) == 1);
    end
    idleCycle();

    // Reset in the middle of a burst while m1 holds parked read data.
    applyReset();
    rr_sel = 1'b0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(NONSEQ, NONSEQ, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, k == 8);
    end
    applyReset();
    @(negedge HCLK);
    HRDATA = 32'h1234_5678;
    #1;
    checkOutput("rhold_cleared_m1", obs_rd1, 32'h1234_5678);
    checkOutput("post_rst_htrans", 32'(obs_trans), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
